// File: rtl/clks_alot_p.sv
// Clock-phase descriptor, clock generator FSM states and edge-decode helper.
package clks_alot_p;

  typedef struct packed {
    logic level;
    logic rising;
    logic falling;
  } clock_state_s;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } gen_state_e;

  // Phase seen through an upcoming toggle: new level plus a one-cycle edge strobe.
  function automatic clock_state_s edge_state(input logic cur_level, input logic toggle);
    clock_state_s st;
    st.level   = cur_level ^ toggle;
    st.rising  = toggle & ~cur_level;
    st.falling = toggle & cur_level;
    return st;
  endfunction

endpackage

// File: rtl/common_p.sv
// Shared clock-domain bundle used across the codebase.
package common_p;

  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;

endpackage

// File: rtl/clk_gen_phase_counter.sv
// Half-period down-counter that produces the free-running reference level,
// an early edge strobe on the terminal-count cycle and a strobe aligned with the level change.
module clk_gen_phase_counter
  import clks_alot_p::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] reload_val,
  input  logic             start_level,
  input  logic             run,
  output logic             level,
  output clock_state_s     pre_edge,
  output clock_state_s     exp_edge
);

  logic [CNT_W-1:0] count_r;
  logic             level_r;
  logic             exp_rise_r;
  logic             exp_fall_r;
  logic             toggle_s;

  // A load always restarts the half period, so it masks a coincident terminal count.
  assign toggle_s = run && !load && (count_r == {CNT_W{1'b0}});

  // Counter, reference level and the edge strobes delayed onto the level change.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r    <= {CNT_W{1'b0}};
      level_r    <= 1'b0;
      exp_rise_r <= 1'b0;
      exp_fall_r <= 1'b0;
    end else begin
      exp_rise_r <= toggle_s & ~level_r;
      exp_fall_r <= toggle_s & level_r;
      if (load) begin
        count_r <= reload_val;
        level_r <= start_level;
      end else if (toggle_s) begin
        count_r <= reload_val;
        level_r <= ~level_r;
      end else if (run) begin
        count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign level    = level_r;
  assign pre_edge = edge_state(level_r, toggle_s);
  assign exp_edge = {level_r, exp_rise_r, exp_fall_r};

endmodule

// File: rtl/sir_clk_gen.sv
// Programmable divided clock for an IO pin with phase-preserving pause and a
// drain phase that always stops the pin on its starting level.
module sir_clk_gen
  import clks_alot_p::*;
#(
  parameter int HALF_PERIOD_W = 16
) (
  input  common_p::clk_dom_s        sys_dom_i,
  input  logic                      generation_en_i,
  input  logic                      starting_polarity_i,
  input  logic [HALF_PERIOD_W-1:0]  half_period_i,
  input  logic                      pause_en_i,
  input  logic                      pause_polarity_i,
  output logic                      io_clk_o,
  output logic                      io_clk_oe_o,
  output clks_alot_p::clock_state_s unpausable_expected_clk_state_o,
  output clks_alot_p::clock_state_s unpausable_preemptive_clk_state_o,
  output clks_alot_p::clock_state_s pausable_expected_clk_state_o,
  output clks_alot_p::clock_state_s pausable_preemptive_clk_state_o,
  output logic                      busy_o,
  output logic                      pause_start_violation_o,
  output logic                      pause_stop_violation_o
);

  logic                     clk_s;
  logic                     rst_n_s;
  gen_state_e               state_r;
  gen_state_e               state_next_s;
  logic                     load_s;
  logic                     run_s;
  logic                     start_r;
  logic [HALF_PERIOD_W-1:0] half_r;
  logic [HALF_PERIOD_W-1:0] reload_val_s;
  logic                     ref_level_s;
  logic                     ref_tog_s;
  logic                     ret_s;
  clock_state_s             unp_pre_s;
  clock_state_s             unp_exp_s;

  logic                     pause_en_d_r;
  logic                     pause_pol_d_r;
  logic                     pause_pol_r;
  logic                     pend_r;
  logic                     held_r;
  logic                     pause_rise_s;
  logic                     hold_enter_s;
  logic                     exit_s;
  logic                     pin_tog_s;
  logic                     pin_next_s;
  logic                     pin_edge_s;

  logic                     pin_r;
  logic                     oe_r;
  logic                     busy_r;
  logic                     pexp_rise_r;
  logic                     pexp_fall_r;
  logic                     start_viol_r;
  logic                     stop_viol_r;

  assign clk_s   = sys_dom_i.clk;
  assign rst_n_s = sys_dom_i.sync_rst;

  assign run_s     = (state_r != ST_IDLE);
  assign ref_tog_s = unp_pre_s.rising | unp_pre_s.falling;
  // Toggle that brings the reference back to the starting level closes a full period.
  assign ret_s     = ref_tog_s && (ref_level_s != start_r);
  assign reload_val_s = (load_s || ret_s) ? half_period_i : half_r;

  clk_gen_phase_counter #(
    .CNT_W (HALF_PERIOD_W)
  ) u_phase (
    .clk         (clk_s),
    .rst_n       (rst_n_s),
    .load        (load_s),
    .reload_val  (reload_val_s),
    .start_level (starting_polarity_i),
    .run         (run_s),
    .level       (ref_level_s),
    .pre_edge    (unp_pre_s),
    .exp_edge    (unp_exp_s)
  );

  // Next-state decode; a DRAIN that sees the enable again resumes without reloading.
  always_comb begin
    state_next_s = state_r;
    load_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (generation_en_i) begin
          state_next_s = ST_RUN;
          load_s       = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!generation_en_i) begin
          state_next_s = ST_DRAIN;
        end else begin
          state_next_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (generation_en_i) begin
          state_next_s = ST_RUN;
        end else if (ret_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  assign pause_rise_s = pause_en_i && !pause_en_d_r;
  // Hold starts as soon as the followed level sits on the captured polarity.
  assign hold_enter_s = pend_r && pause_en_i && (ref_level_s == pause_pol_r);
  assign exit_s       = held_r && !pause_en_i && ref_tog_s && (ref_level_s == pause_pol_r);
  assign pin_tog_s    = ref_tog_s && ((!held_r && !hold_enter_s) || exit_s);

  // Pin level for the next cycle; leaving to IDLE always parks on the starting level.
  always_comb begin
    pin_next_s = pin_r;
    if (load_s) begin
      pin_next_s = starting_polarity_i;
    end else if (state_next_s == ST_IDLE) begin
      pin_next_s = start_r;
    end else begin
      pin_next_s = pin_r ^ pin_tog_s;
    end
  end

  assign pin_edge_s = run_s && (pin_next_s != pin_r);

  // FSM state, latched configuration and registered pin-side outputs.
  always_ff @(posedge clk_s) begin
    if (!rst_n_s) begin
      state_r     <= ST_IDLE;
      start_r     <= 1'b0;
      half_r      <= {HALF_PERIOD_W{1'b0}};
      pin_r       <= 1'b0;
      oe_r        <= 1'b0;
      busy_r      <= 1'b0;
      pexp_rise_r <= 1'b0;
      pexp_fall_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pin_r       <= pin_next_s;
      oe_r        <= (state_next_s != ST_IDLE);
      busy_r      <= (state_next_s != ST_IDLE) || (state_r != ST_IDLE);
      pexp_rise_r <= pin_edge_s & pin_next_s;
      pexp_fall_r <= pin_edge_s & ~pin_next_s;
      if (load_s) begin
        start_r <= starting_polarity_i;
        half_r  <= half_period_i;
      end else if (ret_s) begin
        half_r  <= half_period_i;
      end else begin
        half_r  <= half_r;
      end
    end
  end

  // Pause tracking: request edge, pending/held flags, captured polarity and violations.
  always_ff @(posedge clk_s) begin
    if (!rst_n_s) begin
      pause_en_d_r  <= 1'b0;
      pause_pol_d_r <= 1'b0;
      pause_pol_r   <= 1'b0;
      pend_r        <= 1'b0;
      held_r        <= 1'b0;
      start_viol_r  <= 1'b0;
      stop_viol_r   <= 1'b0;
    end else begin
      pause_en_d_r  <= pause_en_i;
      pause_pol_d_r <= pause_polarity_i;
      start_viol_r  <= pause_rise_s && (state_r != ST_RUN);
      stop_viol_r   <= (pend_r || held_r) && (pause_polarity_i != pause_pol_d_r);
      if (state_next_s == ST_IDLE) begin
        pend_r <= 1'b0;
        held_r <= 1'b0;
      end else if (held_r) begin
        held_r <= !exit_s;
      end else if (pend_r) begin
        if (!pause_en_i) begin
          pend_r <= 1'b0;
        end else if (hold_enter_s) begin
          pend_r <= 1'b0;
          held_r <= 1'b1;
        end else begin
          pend_r <= 1'b1;
        end
      end else if (pause_rise_s && (state_r == ST_RUN)) begin
        pend_r      <= 1'b1;
        pause_pol_r <= pause_polarity_i;
      end else begin
        pend_r <= 1'b0;
      end
    end
  end

  assign io_clk_o                          = pin_r;
  assign io_clk_oe_o                       = oe_r;
  assign busy_o                            = busy_r;
  assign pause_start_violation_o           = start_viol_r;
  assign pause_stop_violation_o            = stop_viol_r;
  assign unpausable_expected_clk_state_o   = unp_exp_s;
  assign unpausable_preemptive_clk_state_o = unp_pre_s;
  assign pausable_expected_clk_state_o     = {pin_r, pexp_rise_r, pexp_fall_r};
  assign pausable_preemptive_clk_state_o   = edge_state(pin_r, pin_edge_s);

endmodule

// File: tb/tb_sir_clk_gen.sv
// Directed bench for sir_clk_gen: expected pin/reference edges are queued with
// their cycle numbers before each scenario and popped as the DUT produces them.
module tb_sir_clk_gen;
  import common_p::*;
  import clks_alot_p::*;

  localparam int W = 16;

  typedef struct {
    int   cyc;
    logic lvl;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n;
  clk_dom_s     dom;
  logic         gen_en;
  logic         start_pol;
  logic [W-1:0] half;
  logic         pause_en;
  logic         pause_pol;
  logic         pin;
  logic         oe;
  logic         busy;
  logic         sviol;
  logic         pviol;
  clock_state_s uexp;
  clock_state_s upre;
  clock_state_s pexp;
  clock_state_s ppre;

  int   cyc;
  int   total;
  int   bad;
  int   t0;
  bit   mon_en;
  bit   chk_pre;
  logic prev_pin;
  ev_t  q_pin[$];
  ev_t  q_uexp[$];
  ev_t  q_upre[$];

  assign dom = {clk, rst_n};

  always #5 clk = ~clk;

  sir_clk_gen #(.HALF_PERIOD_W(W)) dut (
    .sys_dom_i                         (dom),
    .generation_en_i                   (gen_en),
    .starting_polarity_i               (start_pol),
    .half_period_i                     (half),
    .pause_en_i                        (pause_en),
    .pause_polarity_i                  (pause_pol),
    .io_clk_o                          (pin),
    .io_clk_oe_o                       (oe),
    .unpausable_expected_clk_state_o   (uexp),
    .unpausable_preemptive_clk_state_o (upre),
    .pausable_expected_clk_state_o     (pexp),
    .pausable_preemptive_clk_state_o   (ppre),
    .busy_o                            (busy),
    .pause_start_violation_o           (sviol),
    .pause_stop_violation_o            (pviol)
  );

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s at cycle %0d: observed %0d expected %0d", tag, cyc, obs, expv);
    end
  endtask

  // Queue reference edges: first at cycle 'first', then every 'hp' cycles, alternating level.
  task automatic expect_ref(input int first, input int hp, input int count, input logic first_lvl,
                            input bit with_pin);
    logic l;
    l = first_lvl;
    for (int k = 0; k < count; k++) begin
      q_uexp.push_back('{cyc: first + k * hp, lvl: l});
      if (chk_pre) q_upre.push_back('{cyc: first + k * hp - 1, lvl: l});
      if (with_pin) q_pin.push_back('{cyc: first + k * hp, lvl: l});
      l = ~l;
    end
  endtask

  task automatic exp_pin(input int c, input logic l);
    q_pin.push_back('{cyc: c, lvl: l});
  endtask

  // One cycle: sample at the falling edge and score any edge the DUT shows.
  task automatic step();
    ev_t e;
    @(negedge clk);
    cyc++;
    if (mon_en) begin
      if (pin !== prev_pin) begin
        if (q_pin.size() == 0) chk("pin_unexpected_edge", cyc, -1);
        else begin
          e = q_pin.pop_front();
          chk("pin_edge_cycle", cyc, e.cyc);
          chk("pin_edge_level", int'(pin), int'(e.lvl));
        end
      end
      if (uexp.rising || uexp.falling) begin
        if (q_uexp.size() == 0) chk("uexp_unexpected_pulse", cyc, -1);
        else begin
          e = q_uexp.pop_front();
          chk("uexp_pulse_cycle", cyc, e.cyc);
          chk("uexp_pulse_dir", int'(uexp.rising), int'(e.lvl));
        end
      end
      if (chk_pre && (upre.rising || upre.falling)) begin
        if (q_upre.size() == 0) chk("upre_unexpected_pulse", cyc, -1);
        else begin
          e = q_upre.pop_front();
          chk("upre_pulse_cycle", cyc, e.cyc);
          chk("upre_pulse_dir", int'(upre.rising), int'(e.lvl));
        end
      end
    end
    prev_pin = pin;
  endtask

  task automatic run_to(input int target);
    while (cyc < target) step();
  endtask

  task automatic chk_drained(input string tag);
    chk({tag, "_pin_q"}, q_pin.size(), 0);
    chk({tag, "_uexp_q"}, q_uexp.size(), 0);
    chk({tag, "_upre_q"}, q_upre.size(), 0);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; mon_en = 1'b0; chk_pre = 1'b0;
    rst_n = 1'b0; gen_en = 1'b0; start_pol = 1'b0; half = 16'd3;
    pause_en = 1'b0; pause_pol = 1'b0;

    // Reset values
    repeat (3) step();
    chk("rst_pin", int'(pin), 0);
    chk("rst_oe", int'(oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_uexp", int'(uexp), 0);
    chk("rst_upre", int'(upre), 0);
    chk("rst_pexp", int'(pexp), 0);
    chk("rst_ppre", int'(ppre), 0);
    chk("rst_sviol", int'(sviol), 0);
    chk("rst_pviol", int'(pviol), 0);
    rst_n = 1'b1;
    prev_pin = pin;
    mon_en = 1'b1;
    repeat (2) step();

    // N=3, start 0: oe next cycle, first rise 4 cycles later, period 8
    t0 = cyc; half = 16'd3; start_pol = 1'b0; gen_en = 1'b1;
    expect_ref(t0 + 5, 4, 4, 1'b1, 1'b1);
    step();
    chk("a_oe_first", int'(oe), 1);
    chk("a_busy_first", int'(busy), 1);
    chk("a_pin_first", int'(pin), 0);
    run_to(t0 + 14); gen_en = 1'b0;
    run_to(t0 + 17);
    chk("a_oe_idle", int'(oe), 0);
    step();
    chk("a_busy_idle", int'(busy), 0);
    chk_drained("a");

    // N=0: toggle every cycle, preemptive one cycle ahead of expected
    step();
    t0 = cyc; chk_pre = 1'b1; half = 16'd0; gen_en = 1'b1;
    expect_ref(t0 + 2, 1, 8, 1'b1, 1'b1);
    run_to(t0 + 6); gen_en = 1'b0;
    run_to(t0 + 10);
    chk("b_oe_idle", int'(oe), 0);
    chk_drained("b");
    chk_pre = 1'b0;

    // N=2, drop enable while high: drain to the next fall, busy one cycle longer
    step();
    t0 = cyc; half = 16'd2; gen_en = 1'b1;
    expect_ref(t0 + 4, 3, 2, 1'b1, 1'b1);
    run_to(t0 + 5); gen_en = 1'b0;
    run_to(t0 + 6);
    chk("c_oe_drain", int'(oe), 1);
    chk("c_busy_drain", int'(busy), 1);
    step();
    chk("c_oe_idle", int'(oe), 0);
    chk("c_busy_tail", int'(busy), 1);
    chk("c_pin_idle", int'(pin), 0);
    step();
    chk("c_busy_low", int'(busy), 0);
    chk_drained("c");

    // N=3 pause high: pin holds 1, reference keeps running, realigns after release
    step();
    t0 = cyc; half = 16'd3; pause_pol = 1'b1; gen_en = 1'b1;
    exp_pin(t0 + 5, 1'b1);
    exp_pin(t0 + 25, 1'b0);
    exp_pin(t0 + 29, 1'b1);
    exp_pin(t0 + 33, 1'b0);
    expect_ref(t0 + 5, 4, 8, 1'b1, 1'b0);
    run_to(t0 + 7); pause_en = 1'b1;
    run_to(t0 + 11); pause_pol = 1'b0;
    step();
    chk("d_stop_viol", int'(pviol), 1);
    step();
    chk("d_stop_viol_clear", int'(pviol), 0);
    run_to(t0 + 18);
    chk("d_pin_held", int'(pin), 1);
    chk("d_ref_low", int'(uexp.level), 0);
    chk("d_pexp_held", int'(pexp), 4);
    pause_en = 1'b0;
    run_to(t0 + 25);
    chk("d_pexp_resume_fall", int'(pexp), 1);
    run_to(t0 + 30); gen_en = 1'b0;
    run_to(t0 + 34);
    chk("d_oe_idle", int'(oe), 0);
    chk_drained("d");

    // Pause requested in IDLE: single violation pulse, following run unaffected
    step();
    pause_en = 1'b1;
    step();
    chk("e_start_viol", int'(sviol), 1);
    step();
    chk("e_start_viol_clear", int'(sviol), 0);
    t0 = cyc; half = 16'd1; start_pol = 1'b1; gen_en = 1'b1;
    exp_pin(t0 + 1, 1'b1);
    expect_ref(t0 + 3, 2, 4, 1'b0, 1'b1);
    run_to(t0 + 6); gen_en = 1'b0;
    step();
    chk("e_no_start_viol", int'(sviol), 0);
    chk("e_no_stop_viol", int'(pviol), 0);
    run_to(t0 + 11);
    chk("e_pin_idle_start", int'(pin), 1);
    chk("e_oe_idle", int'(oe), 0);
    pause_en = 1'b0;
    chk_drained("e");

    // Half period 3 -> 5 mid-period: current period 8, next 12
    step();
    t0 = cyc; half = 16'd3; start_pol = 1'b1; gen_en = 1'b1;
    expect_ref(t0 + 5, 4, 2, 1'b0, 1'b1);
    expect_ref(t0 + 15, 6, 2, 1'b0, 1'b1);
    run_to(t0 + 3); half = 16'd5;
    run_to(t0 + 16); gen_en = 1'b0;
    run_to(t0 + 22);
    chk("f_oe_idle", int'(oe), 0);
    chk("f_pin_idle", int'(pin), 1);
    chk_drained("f");

    // Reset mid-run takes effect on the next edge with no drain
    step();
    t0 = cyc; half = 16'd3; start_pol = 1'b0; gen_en = 1'b1;
    exp_pin(t0 + 1, 1'b0);
    expect_ref(t0 + 5, 4, 1, 1'b1, 1'b1);
    exp_pin(t0 + 7, 1'b0);
    run_to(t0 + 6); rst_n = 1'b0; gen_en = 1'b0;
    step();
    chk("g_rst_oe", int'(oe), 0);
    chk("g_rst_busy", int'(busy), 0);
    chk("g_rst_pin", int'(pin), 0);
    chk("g_rst_uexp", int'(uexp), 0);
    chk("g_rst_pexp", int'(pexp), 0);
    rst_n = 1'b1;
    run_to(t0 + 10);
    chk("g_oe_after", int'(oe), 0);
    chk("g_busy_after", int'(busy), 0);
    chk_drained("g");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
